// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [INST_W-1:0] NOP_INST_DEF = 32'h0000_0013;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  // Width of counters that must hold 0..depth inclusive.
  function automatic int cred_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(4);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: power-of-2 synchronous FIFO with synchronous clear.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [INST_W-1:0]          wdata,
  output logic [INST_W-1:0]          rdata,
  output logic [cred_w(DEPTH)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cred_w(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [INST_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic              do_pop;
  logic              do_push;

  // Pop wins; a push into a full buffer is only taken alongside a pop.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: credit-limited in-order requests, response buffering,
// and redirect with flush of buffered and in-flight fetches.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEF,
  parameter int                FIFO_DEPTH = 2,
  parameter logic [INST_W-1:0] NOP_INST   = NOP_INST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_stall,
  input  logic              br_ctrl,
  input  logic [ADDR_W-1:0] br_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [INST_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc
);

  localparam int            CW         = cred_w(FIFO_DEPTH);
  localparam logic [CW:0]   CREDIT_MAX = (CW+1)'(FIFO_DEPTH);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] head_pc;
  logic [CW-1:0]     outst;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     count;
  logic [INST_W-1:0] head_inst;
  logic [CW:0]       credit_used;
  logic              pop;
  logic              issue;
  logic              ret;
  logic              drop;
  logic              push;
  logic              fifo_pop;

  assign if_valid    = (count != '0);
  assign pop         = if_valid && !pc_stall;
  assign credit_used = {1'b0, outst} + {1'b0, count} - (CW+1)'(pop);
  assign imem_req    = !rst && !br_ctrl && (credit_used < CREDIT_MAX);
  assign issue       = imem_req && imem_gnt;

  // Saturating return so a protocol violation cannot wrap the in-flight count.
  assign ret      = imem_rvalid && (outst != '0);
  assign drop     = imem_rvalid && (br_ctrl || (drop_cnt != '0));
  assign push     = imem_rvalid && !drop;
  assign fifo_pop = pop && !br_ctrl;

  assign imem_addr = fetch_pc;
  assign if_pc     = head_pc;
  assign if_inst   = if_valid ? head_inst : NOP_INST;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      head_pc  <= RESET_PC;
      outst    <= '0;
      drop_cnt <= '0;
    end else begin
      outst <= outst + CW'(issue) - CW'(ret);
      if (br_ctrl) begin
        fetch_pc <= br_addr;
        head_pc  <= br_addr;
        // outst already counts responses marked stale by an earlier redirect,
        // so every request still in flight after this cycle becomes stale.
        drop_cnt <= outst - CW'(ret);
      end else begin
        if (issue) begin
          fetch_pc <= pc_inc(fetch_pc);
        end
        if (pop) begin
          head_pc <= pc_inc(head_pc);
        end
        if (imem_rvalid && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (br_ctrl),
    .push  (push),
    .pop   (fifo_pop),
    .wdata (imem_rdata),
    .rdata (head_inst),
    .count (count)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: table-driven cycle vectors plus a random-grant order check.
module tb_fetch_ctrl;

  localparam logic [31:0] KEY     = 32'hA5A5_0000;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } req_t;

  typedef struct {
    bit          stall;
    bit          br;
    logic [31:0] baddr;
    bit          hold;
    bit          ev;
    logic [31:0] epc;
    bit          ereq;
    logic [31:0] eaddr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_stall = 1'b0;
  logic        br_ctrl = 1'b0;
  logic [31:0] br_addr = '0;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;

  logic        w_stall = 1'b0;
  logic        w_br = 1'b0;
  logic [31:0] w_baddr = '0;
  logic        w_gnt = 1'b1;
  logic        w_rvalid = 1'b0;
  logic [31:0] w_rdata = '0;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_inst;
  logic [31:0] w_pc;

  int   cyc;
  int   lat;
  bit   hold;
  int   n_chk;
  int   n_fail;
  req_t q0[$];
  req_t q1[$];
  vec_t tv[$];
  logic [31:0] wexp [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

  always #5 clk = ~clk;

  fetch_ctrl u_dut (
    .clk         (clk),
    .rst         (rst),
    .pc_stall    (pc_stall),
    .br_ctrl     (br_ctrl),
    .br_addr     (br_addr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_inst     (if_inst),
    .if_pc       (if_pc)
  );

  fetch_ctrl #(
    .RESET_PC (WRAP_PC)
  ) u_wrap (
    .clk         (clk),
    .rst         (rst),
    .pc_stall    (w_stall),
    .br_ctrl     (w_br),
    .br_addr     (w_baddr),
    .imem_req    (w_req),
    .imem_addr   (w_addr),
    .imem_gnt    (w_gnt),
    .imem_rvalid (w_rvalid),
    .imem_rdata  (w_rdata),
    .if_valid    (w_valid),
    .if_inst     (w_inst),
    .if_pc       (w_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: record grants into the memory model, advance, drive this cycle's responses.
  task automatic tick();
    logic was_rst;
    #1;
    was_rst = rst;
    if (imem_req && imem_gnt) q0.push_back(req_t'{cyc + lat, imem_addr});
    if (w_req && w_gnt) q1.push_back(req_t'{cyc + 1, w_addr});
    @(posedge clk);
    #1;
    cyc++;
    if (was_rst) begin
      q0.delete();
      q1.delete();
    end
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (q0.size() > 0 && q0[0].due <= cyc && !hold) begin
      imem_rvalid = 1'b1;
      imem_rdata  = q0[0].addr ^ KEY;
      void'(q0.pop_front());
    end
    w_rvalid = 1'b0;
    w_rdata  = '0;
    if (q1.size() > 0 && q1[0].due <= cyc) begin
      w_rvalid = 1'b1;
      w_rdata  = q1[0].addr ^ KEY;
      void'(q1.pop_front());
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    pc_stall = 1'b0;
    br_ctrl = 1'b0;
    hold = 1'b0;
    imem_gnt = 1'b1;
    repeat (n) tick();
    #1;
    chk("rst valid", 32'(if_valid), 32'd0);
    chk("rst inst", if_inst, NOP);
    chk("rst pc", if_pc, 32'h0);
    chk("rst addr", imem_addr, 32'h0);
    chk("rst req", 32'(imem_req), 32'd0);
    chk("rst wrap pc", w_pc, WRAP_PC);
    chk("rst wrap addr", w_addr, WRAP_PC);
    chk("rst wrap inst", w_inst, NOP);
    rst = 1'b0;
  endtask

  function automatic vec_t mk(bit stall, bit br, logic [31:0] baddr, bit hld,
                              bit ev, logic [31:0] epc, bit ereq, logic [31:0] eaddr);
    vec_t v;
    v.stall = stall;
    v.br    = br;
    v.baddr = baddr;
    v.hold  = hld;
    v.ev    = ev;
    v.epc   = epc;
    v.ereq  = ereq;
    v.eaddr = eaddr;
    return v;
  endfunction

  task automatic run_vecs(input string tag, input bit wchk);
    for (int i = 0; i < tv.size(); i++) begin
      pc_stall = tv[i].stall;
      br_ctrl  = tv[i].br;
      br_addr  = tv[i].baddr;
      hold     = tv[i].hold;
      imem_gnt = 1'b1;
      #1;
      chk($sformatf("%s[%0d] valid", tag, i), 32'(if_valid), 32'(tv[i].ev));
      chk($sformatf("%s[%0d] inst", tag, i), if_inst, tv[i].ev ? (tv[i].epc ^ KEY) : NOP);
      if (tv[i].ev) chk($sformatf("%s[%0d] pc", tag, i), if_pc, tv[i].epc);
      chk($sformatf("%s[%0d] req", tag, i), 32'(imem_req), 32'(tv[i].ereq));
      chk($sformatf("%s[%0d] addr", tag, i), imem_addr, tv[i].eaddr);
      if (wchk && i >= 2 && i <= 4) begin
        chk($sformatf("wrap[%0d] valid", i), 32'(w_valid), 32'd1);
        chk($sformatf("wrap[%0d] pc", i), w_pc, wexp[i-2]);
        chk($sformatf("wrap[%0d] inst", i), w_inst, wexp[i-2] ^ KEY);
      end
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] pend_addr;
    logic        pend;
    int          pops;

    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    lat = 1;
    hold = 1'b0;

    // Streaming, stall back-pressure, then redirect with one stale response in flight.
    do_reset(3);
    tv.delete();
    tv.push_back(mk(0, 0, 0, 0, 0, 32'h00, 1, 32'h00));
    tv.push_back(mk(0, 0, 0, 0, 0, 32'h00, 1, 32'h04));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h00, 1, 32'h08));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h04, 1, 32'h0C));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h08, 1, 32'h10));
    for (int k = 0; k < 5; k++) tv.push_back(mk(1, 0, 0, 0, 1, 32'h0C, 0, 32'h14));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h0C, 1, 32'h14));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h10, 1, 32'h18));
    tv.push_back(mk(0, 0, 0, 1, 1, 32'h14, 1, 32'h1C));
    tv.push_back(mk(0, 1, 32'h100, 0, 1, 32'h18, 0, 32'h20));
    tv.push_back(mk(0, 0, 0, 0, 0, 32'h0, 1, 32'h100));
    tv.push_back(mk(0, 0, 0, 0, 0, 32'h0, 1, 32'h104));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h100, 1, 32'h108));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h104, 1, 32'h10C));
    run_vecs("seq", 1'b1);

    // Back-to-back redirects against a 3-cycle memory, entered by reset mid-stream.
    lat = 3;
    do_reset(2);
    tv.delete();
    tv.push_back(mk(0, 0, 0, 0, 0, 32'h0, 1, 32'h00));
    tv.push_back(mk(0, 0, 0, 0, 0, 32'h0, 1, 32'h04));
    tv.push_back(mk(0, 1, 32'h200, 0, 0, 32'h0, 0, 32'h08));
    tv.push_back(mk(0, 1, 32'h300, 0, 0, 32'h0, 0, 32'h200));
    tv.push_back(mk(0, 0, 0, 0, 0, 32'h0, 1, 32'h300));
    tv.push_back(mk(0, 0, 0, 0, 0, 32'h0, 1, 32'h304));
    tv.push_back(mk(0, 0, 0, 0, 0, 32'h0, 0, 32'h308));
    tv.push_back(mk(0, 0, 0, 0, 0, 32'h0, 0, 32'h308));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h300, 1, 32'h308));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h304, 1, 32'h30C));
    tv.push_back(mk(0, 0, 0, 0, 0, 32'h0, 0, 32'h310));
    tv.push_back(mk(0, 0, 0, 0, 0, 32'h0, 0, 32'h310));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h308, 1, 32'h310));
    run_vecs("bb", 1'b0);

    // Random grant and stall: order preserved, address stable while waiting for grant.
    lat = 1;
    do_reset(2);
    exp_pc = 32'h0;
    pend = 1'b0;
    pend_addr = '0;
    pops = 0;
    for (int i = 0; i < 300; i++) begin
      imem_gnt = 1'($urandom_range(0, 1));
      pc_stall = ($urandom_range(0, 3) == 0);
      br_ctrl  = 1'b0;
      #1;
      if (pend) chk($sformatf("rnd[%0d] addr hold", i), imem_addr, pend_addr);
      if (if_valid && !pc_stall) begin
        chk($sformatf("rnd[%0d] pc", i), if_pc, exp_pc);
        chk($sformatf("rnd[%0d] inst", i), if_inst, exp_pc ^ KEY);
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      pend = imem_req && !imem_gnt;
      pend_addr = imem_addr;
      tick();
    end
    chk("rnd progress", 32'(pops >= 50), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
